// File: rtl/commit_pkg.sv
// Shared constants for the commit tracker: halt codes, FSM encoding and the
// ebreak instruction word.
package commit_pkg;

    localparam logic [1:0] CT_RUN  = 2'd0;
    localparam logic [1:0] CT_GOOD = 2'd1;
    localparam logic [1:0] CT_BAD  = 2'd2;
    localparam logic [1:0] CT_FAIL = 2'd3;

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_GOOD  = 3'd1;
    localparam logic [2:0] ST_BAD   = 3'd2;
    localparam logic [2:0] ST_TMO   = 3'd3;
    localparam logic [2:0] ST_PCERR = 3'd4;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    localparam logic [63:0] CT_RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    localparam int unsigned IDLE_W = 21;

endpackage

// File: rtl/commit_trace_ring.sv
// Ring of the most recent retired pre_pc values; read index 0 is the newest
// entry. Only built when COMMIT_TRACKER_TRACE_EN is defined.
module commit_trace_ring
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [63:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [63:0]              rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [63:0]   mem_p0 [DEPTH];
    logic [AW-1:0] wptr_p0;
    logic [AW-1:0] rd_addr;

    // Power-of-two depth makes the AW-bit subtraction wrap modulo DEPTH.
    assign rd_addr = wptr_p0 - AW'(1) - rd_idx;
    assign rd_data = mem_p0[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_p0 <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_p0[i] <= '0;
            end
        end else if (wr_en) begin
            mem_p0[wptr_p0] <= wr_data;
            wptr_p0         <= wptr_p0 + AW'(1);
        end
    end

endmodule

// File: rtl/commit_tracker.sv
// Commit-stream sink: retire counter, PC-chain check, ebreak halt and idle
// watchdog. Define COMMIT_TRACKER_TRACE_EN to add the pre_pc trace ring.
module commit_tracker
    import commit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] RESET_PC       = CT_RESET_PC_DEFAULT,
    parameter int unsigned TRACE_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regW_i_commit,
    input  logic [63:0]           regW_i_commit_pre_pc,
    input  logic [31:0]           regW_i_commit_instr,
    input  logic [63:0]           regW_i_commit_pc,
    input  logic [63:0]           regW_i_a0,
    output logic [63:0]           ct_o_instr_cnt,
    output logic                  ct_o_halt,
    output logic [1:0]            ct_o_halt_code,
    output logic [63:0]           ct_o_err_pc,
    output logic [IDLE_W-1:0]     ct_o_idle_cnt
`ifdef COMMIT_TRACKER_TRACE_EN
    ,
    output logic [63:0]                    ct_o_trace_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] ct_i_trace_idx
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_timeout
        $error("commit_tracker: TIMEOUT_CYCLES out of range");
    end
    if (TRACE_DEPTH < 2 || TRACE_DEPTH > 64 ||
        (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("commit_tracker: TRACE_DEPTH must be a power of two in 2..64");
    end

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (&v) ? v : v + IDLE_W'(1);
    endfunction

    logic [2:0]        state_p0,   state_nxt;
    logic [63:0]       cnt_p0,     cnt_nxt;
    logic              halt_p0,    halt_nxt;
    logic [1:0]        code_p0,    code_nxt;
    logic [63:0]       err_pc_p0,  err_pc_nxt;
    logic [IDLE_W-1:0] idle_p0,    idle_nxt;
    logic [63:0]       exp_pc_p0,  exp_pc_nxt;

    logic run;
    logic pc_ok;
    logic is_ebreak;
    logic count_en;

    assign run       = (state_p0 == ST_RUN);
    assign pc_ok     = (regW_i_commit_pre_pc == exp_pc_p0);
    assign is_ebreak = (regW_i_commit_instr == EBREAK_INSTR);
    assign count_en  = run && regW_i_commit && pc_ok;

    always_comb begin
        state_nxt  = state_p0;
        cnt_nxt    = cnt_p0;
        halt_nxt   = halt_p0;
        code_nxt   = code_p0;
        err_pc_nxt = err_pc_p0;
        idle_nxt   = idle_p0;
        exp_pc_nxt = exp_pc_p0;
        if (run) begin
            if (regW_i_commit) begin
                idle_nxt = '0;
                // A broken PC chain wins over an ebreak on the same beat.
                if (!pc_ok) begin
                    state_nxt  = ST_PCERR;
                    halt_nxt   = 1'b1;
                    code_nxt   = CT_FAIL;
                    err_pc_nxt = regW_i_commit_pre_pc;
                end else begin
                    cnt_nxt    = cnt_p0 + 64'd1;
                    exp_pc_nxt = regW_i_commit_pc;
                    if (is_ebreak) begin
                        halt_nxt = 1'b1;
                        if (regW_i_a0 == 64'd0) begin
                            state_nxt = ST_GOOD;
                            code_nxt  = CT_GOOD;
                        end else begin
                            state_nxt = ST_BAD;
                            code_nxt  = CT_BAD;
                        end
                    end
                end
            end else begin
                idle_nxt = sat_inc(idle_p0);
                if (idle_p0 >= IDLE_LAST) begin
                    state_nxt  = ST_TMO;
                    halt_nxt   = 1'b1;
                    code_nxt   = CT_FAIL;
                    err_pc_nxt = '0;
                end
            end
        end
    end

    // Single register stage: every output is the state after the last edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0  <= ST_RUN;
            cnt_p0    <= '0;
            halt_p0   <= 1'b0;
            code_p0   <= CT_RUN;
            err_pc_p0 <= '0;
            idle_p0   <= '0;
            exp_pc_p0 <= RESET_PC;
        end else begin
            state_p0  <= state_nxt;
            cnt_p0    <= cnt_nxt;
            halt_p0   <= halt_nxt;
            code_p0   <= code_nxt;
            err_pc_p0 <= err_pc_nxt;
            idle_p0   <= idle_nxt;
            exp_pc_p0 <= exp_pc_nxt;
        end
    end

    assign ct_o_instr_cnt = cnt_p0;
    assign ct_o_halt      = halt_p0;
    assign ct_o_halt_code = code_p0;
    assign ct_o_err_pc    = err_pc_p0;
    assign ct_o_idle_cnt  = idle_p0;

`ifdef COMMIT_TRACKER_TRACE_EN
    commit_trace_ring #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (count_en),
        .wr_data (regW_i_commit_pre_pc),
        .rd_idx  (ct_i_trace_idx),
        .rd_data (ct_o_trace_pc)
    );
`else
    logic unused_count_en;
    assign unused_count_en = count_en;
`endif

endmodule

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker with a queue-based reference model.
// Define COMMIT_TRACKER_TRACE_EN to also check the trace ring.
module tb_commit_tracker;

    localparam int unsigned TMO    = 16;
    localparam int unsigned DEPTH  = 8;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit = 1'b0;
    logic [63:0] pre_pc = '0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic [63:0] a0 = '0;
    logic [63:0] instr_cnt;
    logic        halt;
    logic [1:0]  halt_code;
    logic [63:0] err_pc;
    logic [20:0] idle_cnt;
`ifdef COMMIT_TRACKER_TRACE_EN
    logic [63:0] trace_pc;
    logic [2:0]  trace_idx = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_tracker #(
        .TIMEOUT_CYCLES (TMO),
        .RESET_PC       (RST_PC),
        .TRACE_DEPTH    (DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .regW_i_commit        (commit),
        .regW_i_commit_pre_pc (pre_pc),
        .regW_i_commit_instr  (instr),
        .regW_i_commit_pc     (pc),
        .regW_i_a0            (a0),
        .ct_o_instr_cnt       (instr_cnt),
        .ct_o_halt            (halt),
        .ct_o_halt_code       (halt_code),
        .ct_o_err_pc          (err_pc),
        .ct_o_idle_cnt        (idle_cnt)
`ifdef COMMIT_TRACKER_TRACE_EN
        ,
        .ct_o_trace_pc        (trace_pc),
        .ct_i_trace_idx       (trace_idx)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what has retired so far, and whether we are halted.
    logic        m_valid = 1'b0;
    logic [63:0] m_cnt, m_err, m_exp;
    logic [1:0]  m_code;
    logic [20:0] m_idle;
    logic [63:0] hist[$];

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt   <= '0;
            m_code  <= 2'd0;
            m_err   <= '0;
            m_idle  <= '0;
            m_exp   <= RST_PC;
            m_valid <= 1'b1;
            hist.delete();
        end else if (m_code == 2'd0) begin
            if (commit) begin
                m_idle <= '0;
                if (pre_pc !== m_exp) begin
                    m_code <= 2'd3;
                    m_err  <= pre_pc;
                end else begin
                    m_cnt <= m_cnt + 64'd1;
                    m_exp <= pc;
                    hist.push_back(pre_pc);
                    if (instr == EBRK) m_code <= (a0 == 64'd0) ? 2'd1 : 2'd2;
                end
            end else begin
                if (int'(m_idle) + 1 >= int'(TMO)) m_code <= 2'd3;
                if (m_idle != 21'h1F_FFFF) m_idle <= m_idle + 21'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("instr_cnt", instr_cnt, m_cnt);
            chk("halt", {63'd0, halt}, {63'd0, (m_code != 2'd0)});
            chk("halt_code", {62'd0, halt_code}, {62'd0, m_code});
            chk("err_pc", err_pc, m_err);
            chk("idle_cnt", {43'd0, idle_cnt}, {43'd0, m_idle});
`ifdef COMMIT_TRACKER_TRACE_EN
            begin
                int n;
                logic [63:0] e;
                n = hist.size();
                e = (int'(trace_idx) < n) ? hist[n - 1 - int'(trace_idx)] : 64'd0;
                chk("trace_pc", trace_pc, e);
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic beat(input logic c, input logic [63:0] p, input logic [31:0] ins,
                        input logic [63:0] a);
        commit = c;
        pre_pc = p;
        instr  = ins;
        pc     = p + 64'd4;
        a0     = a;
`ifdef COMMIT_TRACKER_TRACE_EN
        trace_idx = 3'($urandom_range(0, 7));
`endif
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            // Garbage on the payload must not matter when commit is low.
            beat(1'b0, 64'($urandom), $urandom, 64'($urandom));
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        commit = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        do_reset();
        chk("rst_cnt", instr_cnt, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_err", err_pc, 64'd0);

        // Three chained commits
        beat(1'b1, 64'h8000_0000, NOP, 0);
        beat(1'b1, 64'h8000_0004, NOP, 0);
        beat(1'b1, 64'h8000_0008, NOP, 0);
        chk("chain_cnt", instr_cnt, 64'd3);
        chk("chain_code", {62'd0, halt_code}, 64'd0);

        // Broken chain: expected 8000_000C
        beat(1'b1, 64'h8000_0010, NOP, 0);
        chk("pcerr_halt", {63'd0, halt}, 64'd1);
        chk("pcerr_code", {62'd0, halt_code}, 64'd3);
        chk("pcerr_err", err_pc, 64'h8000_0010);
        chk("pcerr_cnt", instr_cnt, 64'd3);
        beat(1'b1, 64'h8000_000C, NOP, 0);
        chk("pcerr_frozen_cnt", instr_cnt, 64'd3);
        idle(3);
        chk("pcerr_frozen_idle", {43'd0, idle_cnt}, 64'd0);

        // Good trap
        do_reset();
        beat(1'b1, 64'h8000_0000, NOP, 0);
        beat(1'b1, 64'h8000_0004, NOP, 0);
        beat(1'b1, 64'h8000_0008, EBRK, 0);
        chk("good_code", {62'd0, halt_code}, 64'd1);
        chk("good_cnt", instr_cnt, 64'd3);
        beat(1'b1, 64'h8000_000C, NOP, 0);
        chk("good_frozen", instr_cnt, 64'd3);

        // Reset mid-halt, then bad trap
        do_reset();
        chk("rehalt_halt", {63'd0, halt}, 64'd0);
        chk("rehalt_code", {62'd0, halt_code}, 64'd0);
        beat(1'b1, 64'h8000_0000, NOP, 0);
        chk("rehalt_cnt", instr_cnt, 64'd1);
        beat(1'b1, 64'h8000_0004, EBRK, 64'd5);
        chk("bad_code", {62'd0, halt_code}, 64'd2);
        chk("bad_cnt", instr_cnt, 64'd2);

        // PC error beats ebreak on the same beat
        do_reset();
        beat(1'b1, 64'h8000_0040, EBRK, 0);
        chk("prio_code", {62'd0, halt_code}, 64'd3);
        chk("prio_cnt", instr_cnt, 64'd0);

        // Timeout on the 16th idle cycle, not the 15th
        do_reset();
        idle(15);
        chk("tmo15_halt", {63'd0, halt}, 64'd0);
        chk("tmo15_idle", {43'd0, idle_cnt}, 64'd15);
        idle(1);
        chk("tmo16_halt", {63'd0, halt}, 64'd1);
        chk("tmo16_code", {62'd0, halt_code}, 64'd3);
        chk("tmo16_err", err_pc, 64'd0);

        // A commit on the would-be 16th idle cycle defers the timeout
        do_reset();
        idle(15);
        beat(1'b1, 64'h8000_0000, NOP, 0);
        chk("tmo_defer_halt", {63'd0, halt}, 64'd0);
        chk("tmo_defer_idle", {43'd0, idle_cnt}, 64'd0);
        idle(15);
        chk("tmo_defer2_halt", {63'd0, halt}, 64'd0);
        idle(1);
        chk("tmo_defer3_halt", {63'd0, halt}, 64'd1);

        // Ten chained commits, exercising ring wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 64'h8000_0000 + 64'(4 * i), NOP, 0);
        end
        chk("ten_cnt", instr_cnt, 64'd10);
`ifdef COMMIT_TRACKER_TRACE_EN
        trace_idx = 3'd0;
        #1;
        chk("trace_idx0", trace_pc, 64'h8000_0024);
        trace_idx = 3'd7;
        #1;
        chk("trace_idx7", trace_pc, 64'h8000_0008);
        step();
`endif
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
